// File: rtl/fp_seq_unit.sv
// fp_seq_unit: self-sequenced floating-point add/sub/mul with start/busy/done handshake.
// Significand layout: {carry, hidden, fraction, guard, round, sticky}.
module fp_seq_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [1:0]             op_i,
  input  logic [EXP_W+MAN_W:0]   op_a_i,
  input  logic [EXP_W+MAN_W:0]   op_b_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [EXP_W+MAN_W:0]   result_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
  output logic                   zero_o
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 5;
  localparam int N  = MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic signed [EW-1:0] EMAX = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] EZ   = '0;
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, OPERATE, NORM, ROUND, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic signed [EW-1:0] exp_q, exp_d, e2;
  logic sign_q, sign_d, zf_q, zf_d, ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;
  logic [SW-1:0] sig_q, sig_d, sml_q, sml_d, sm_sig, sh, addsub, mul_sig;
  logic [2*N-1:0] prod_q, prod_d, prod_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EXP_W-1:0] ea, eb, el, es, d;
  logic [MAN_W-1:0] fa, fb, fr;
  logic [W-2:0] lg, sm;
  logic [N:0] acc;
  logic [MAN_W+1:0] m;
  logic is_mul, bs_eff, inf_s, swp, st, rnd_up;
  assign ea     = a_q[W-2 -: EXP_W];
  assign eb     = b_q[W-2 -: EXP_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign is_mul = op_q == 2'b10;
  assign bs_eff = b_q[W-1] ^ (op_q == 2'b01);
  assign inf_s  = is_mul ? a_q[W-1] ^ b_q[W-1] : (&ea ? a_q[W-1] : bs_eff);
  // Magnitude order of {exp, frac} is plain unsigned order of the low bits.
  assign swp    = b_q[W-2:0] > a_q[W-2:0];
  assign lg     = swp ? b_q[W-2:0] : a_q[W-2:0];
  assign sm     = swp ? a_q[W-2:0] : b_q[W-2:0];
  assign el     = lg[W-2 -: EXP_W];
  assign es     = sm[W-2 -: EXP_W];
  assign d      = el - es;
  assign sm_sig = {1'b0, |es, sm[MAN_W-1:0], 3'b000};
  assign sh     = 32'(d) >= SW ? '0 : sm_sig >> d;
  assign st     = 32'(d) >= SW ? |sm_sig : |(sm_sig & ~({SW{1'b1}} << d));
  assign addsub = (a_q[W-1] == b_q[W-1]) ? sig_q + sml_q : sig_q - sml_q;
  assign acc     = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, sml_q[N-1:0]} : '0);
  assign prod_nx = {acc, prod_q[N-1:1]};
  assign mul_sig = {prod_nx[2*N-1 -: SW-1], |prod_nx[2*N-SW:0]};
  assign rnd_up = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
  assign m      = {1'b0, sig_q[SW-2:3]} + (MAN_W+2)'(rnd_up);
  assign e2     = exp_q + EW'(m[MAN_W+1]);
  assign fr     = m[MAN_W+1] ? m[MAN_W:1] : m[MAN_W-1:0];
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    zf_d    = zf_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;
    sig_d   = sig_q;
    sml_d   = sml_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = UNPACK;
        op_d    = op_i;
        a_d     = op_a_i;
        b_d     = op_b_i;
        zf_d    = 1'b0;
        cnt_d   = '0;
      end
      UNPACK: begin
        a_d     = {a_q[W-1:MAN_W], fa & {MAN_W{|ea}}};
        b_d     = {bs_eff, b_q[W-2:MAN_W], fb & {MAN_W{|eb}}};
        state_d = ALIGN;
        if (&ea || &eb) begin
          state_d = DONE;
          res_d   = {inf_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d   = 1'b1;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
        end
      end
      ALIGN: begin
        state_d = OPERATE;
        if (is_mul) begin
          sign_d = a_q[W-1] ^ b_q[W-1];
          exp_d  = EW'(int'(ea) + int'(eb) - BIAS);
          prod_d = {{N{1'b0}}, |eb, fb};
          sml_d  = SW'({|ea, fa});
        end else begin
          sign_d = swp ? b_q[W-1] : a_q[W-1];
          exp_d  = EW'(el);
          sig_d  = {1'b0, |el, lg[MAN_W-1:0], 3'b000};
          sml_d  = sh | SW'(st);
        end
      end
      OPERATE: if (is_mul) begin
        prod_d = prod_nx;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(MAN_W)) begin
          sig_d   = mul_sig;
          state_d = NORM;
        end
      end else begin
        sig_d   = addsub;
        sign_d  = (addsub == '0) ? 1'b0 : sign_q;
        state_d = NORM;
      end
      NORM: begin
        state_d = ROUND;
        if (sig_q == '0) zf_d = 1'b1;
        else if (sig_q[SW-1]) begin
          sig_d = {1'b0, sig_q[SW-1:2], |sig_q[1:0]};
          exp_d = exp_q + EW'(1);
        end else if (!sig_q[SW-2]) begin
          sig_d   = sig_q << 1;
          exp_d   = exp_q - EW'(1);
          state_d = sig_q[SW-3] ? ROUND : NORM;
        end
      end
      ROUND: begin
        state_d = DONE;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        zero_d  = 1'b0;
        res_d   = {sign_q, e2[EXP_W-1:0], fr};
        if (zf_q) begin
          res_d  = {sign_q, {(W-1){1'b0}}};
          zero_d = 1'b1;
        end else if (e2 >= EMAX) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (e2 <= EZ) begin
          res_d  = {sign_q, {(W-1){1'b0}}};
          unf_d  = 1'b1;
          zero_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      zf_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
      sig_q   <= '0;
      sml_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      zf_q    <= zf_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
      sig_q   <= sig_d;
      sml_q   <= sml_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy_o      = state_q != IDLE && state_q != DONE;
  assign done_o      = state_q == DONE;
  assign result_o    = res_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign zero_o      = zero_q;
endmodule
